// File: rtl/inst_array_collector_if.sv
// Output stream of the instance-array collector: one tagged word per transfer,
// accepted when out_valid && out_ready.
interface inst_array_collector_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned ROW_W = 2,
  parameter int unsigned COL_W = 1
);
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/inst_array_collector.sv
// Snapshots a ROWS x COLS array of W-bit instance words and streams them out in
// row-major order with [row][col] tags and a running XOR checksum.
module inst_array_collector #(
  parameter int unsigned ROWS  = 3,
  parameter int unsigned COLS  = 2,
  parameter int unsigned W     = 8,
  parameter int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ROWS*COLS*W-1:0]   in_data,
  inst_array_collector_if.master   out_if,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             checksum
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [N*W-1:0]      r_snap;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [IDX_W-1:0]    r_idx;
  logic                r_valid;
  logic [W-1:0]        r_data;
  logic                r_last;
  logic                r_busy;
  logic                r_done;
  logic [W-1:0]        r_chk;

  logic                w_xfer;
  logic                w_col_wrap;
  logic [ROW_W-1:0]    w_next_row;
  logic [COL_W-1:0]    w_next_col;
  logic [IDX_W-1:0]    w_next_idx;
  logic                w_next_last;
  logic [W-1:0]        w_next_data;

  assign w_xfer      = r_valid && out_if.out_ready;
  assign w_col_wrap  = (r_col == COL_W'(COLS - 1));
  assign w_next_col  = w_col_wrap ? '0 : r_col + COL_W'(1);
  assign w_next_row  = w_col_wrap ? r_row + ROW_W'(1) : r_row;
  assign w_next_idx  = r_idx + IDX_W'(1);
  assign w_next_last = (w_next_row == ROW_W'(ROWS - 1)) && (w_next_col == COL_W'(COLS - 1));

  // Output data is registered, so the following element is selected one
  // transfer ahead from the linear index that tracks (row, col).
  always_comb begin
    w_next_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_next_idx == IDX_W'(i)) begin
        w_next_data = r_snap[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_chk   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_snap  <= in_data;
            r_row   <= '0;
            r_col   <= '0;
            r_idx   <= '0;
            r_chk   <= '0;
            r_valid <= 1'b1;
            r_data  <= in_data[W-1:0];
            r_last  <= (N == 1);
            r_busy  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_chk <= r_chk ^ r_data;
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_row  <= w_next_row;
              r_col  <= w_next_col;
              r_idx  <= w_next_idx;
              r_data <= w_next_data;
              r_last <= w_next_last;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.out_data  = r_data;
  assign out_if.out_row   = r_row;
  assign out_if.out_col   = r_col;
  assign out_if.out_last  = r_last;
  assign busy             = r_busy;
  assign done             = r_done;
  assign checksum         = r_chk;

endmodule

// File: tb/tb_inst_array_collector.sv
// Directed bench for inst_array_collector: a 3x2 instance and a degenerate 1x1 instance.
module tb_inst_array_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [47:0] in_a = '0;
  logic [7:0]  in_b = '0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [7:0]  chk_a, chk_b;

  int total = 0;
  int bad   = 0;

  localparam logic [47:0] BASE = 48'h21_20_11_10_01_00;
  logic [7:0] exp_word [6] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21};

  inst_array_collector_if #(.W(8), .ROW_W(2), .COL_W(1)) bus_a ();
  inst_array_collector_if #(.W(8), .ROW_W(1), .COL_W(1)) bus_b ();

  inst_array_collector #(.ROWS(3), .COLS(2), .W(8), .ROW_W(2), .COL_W(1)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_a),
    .in_data  (in_a),
    .out_if   (bus_a.master),
    .busy     (busy_a),
    .done     (done_a),
    .checksum (chk_a)
  );

  inst_array_collector #(.ROWS(1), .COLS(1), .W(8), .ROW_W(1), .COL_W(1)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_b),
    .in_data  (in_b),
    .out_if   (bus_b.master),
    .busy     (busy_b),
    .done     (done_b),
    .checksum (chk_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input int k);
    chk({tag, "_valid"}, 32'(bus_a.out_valid), 32'd1);
    chk({tag, "_data"},  32'(bus_a.out_data),  32'(exp_word[k]));
    chk({tag, "_row"},   32'(bus_a.out_row),   32'(k / 2));
    chk({tag, "_col"},   32'(bus_a.out_col),   32'(k % 2));
    chk({tag, "_last"},  32'(bus_a.out_last),  32'(k == 5));
  endtask

  initial begin
    int k;
    int cyc;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    in_a = BASE;
    in_b = 8'hA5;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_chk",   32'(chk_a),  32'd0);
    chk("rst_data",  32'(bus_a.out_data), 32'd0);

    // 1: full-rate scan
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_word("s1", i);
      chk("s1_busy", 32'(busy_a), 32'd1);
      tick();
    end
    chk("s1_done",     32'(done_a), 32'd1);
    chk("s1_valid_lo", 32'(bus_a.out_valid), 32'd0);
    chk("s1_chk",      32'(chk_a), 32'h01);
    chk("s1_busy_dn",  32'(busy_a), 32'd1);
    tick();
    chk("s1_done_end", 32'(done_a), 32'd0);
    chk("s1_busy_end", 32'(busy_a), 32'd0);

    // 2: back-pressure, ready high every third cycle
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 6 && cyc < 40) begin
      bus_a.out_ready = (cyc % 3 == 0);
      check_word("s2", k);
      chk("s2_done_lo", 32'(done_a), 32'd0);
      if (bus_a.out_ready) k++;
      cyc++;
      tick();
    end
    chk("s2_count", 32'(k), 32'd6);
    bus_a.out_ready = 1'b1;
    chk("s2_done", 32'(done_a), 32'd1);
    chk("s2_chk",  32'(chk_a), 32'h01);
    tick();

    // 3: input changes after capture do not affect the stream
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    in_a = '1;
    for (int i = 0; i < 6; i++) begin
      check_word("s3", i);
      tick();
    end
    chk("s3_done", 32'(done_a), 32'd1);
    chk("s3_chk",  32'(chk_a), 32'h01);
    in_a = BASE;
    tick();

    // 4: start during SEND is ignored; start right after done restarts
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    k = 0;
    cyc = 0;
    while (!done_a && cyc < 20) begin
      if (bus_a.out_valid) begin
        if (k < 6) chk("s4_data", 32'(bus_a.out_data), 32'(exp_word[k]));
        start_a = (k == 3);
        k++;
      end else begin
        start_a = 1'b0;
      end
      cyc++;
      tick();
    end
    start_a = 1'b0;
    chk("s4_words", 32'(k), 32'd6);
    chk("s4_done",  32'(done_a), 32'd1);
    tick();
    chk("s4_idle_busy",  32'(busy_a), 32'd0);
    chk("s4_idle_valid", 32'(bus_a.out_valid), 32'd0);
    chk("s4_idle_done",  32'(done_a), 32'd0);
    chk("s4_chk_held",   32'(chk_a), 32'h01);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_word("s4_restart", 0);
    chk("s4_chk_clr", 32'(chk_a), 32'h00);
    for (int i = 0; i < 6; i++) tick();
    chk("s4_done2", 32'(done_a), 32'd1);
    tick();

    // 5: asynchronous reset mid-scan
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    tick();
    chk("s5_pre_data", 32'(bus_a.out_data), 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_valid", 32'(bus_a.out_valid), 32'd0);
    chk("s5_busy",  32'(busy_a), 32'd0);
    chk("s5_done",  32'(done_a), 32'd0);
    chk("s5_chk",   32'(chk_a), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chk("s5_nodone", 32'(done_a), 32'd0);
    chk("s5_idle",   32'(busy_a), 32'd0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_word("s5_restart", 0);
    for (int i = 0; i < 7; i++) tick();
    chk("s5_end_busy", 32'(busy_a), 32'd0);

    // 6: degenerate 1x1 array
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("s6_valid", 32'(bus_b.out_valid), 32'd1);
    chk("s6_data",  32'(bus_b.out_data),  32'hA5);
    chk("s6_last",  32'(bus_b.out_last),  32'd1);
    chk("s6_row",   32'(bus_b.out_row),   32'd0);
    chk("s6_col",   32'(bus_b.out_col),   32'd0);
    tick();
    chk("s6_done",     32'(done_b), 32'd1);
    chk("s6_valid_lo", 32'(bus_b.out_valid), 32'd0);
    chk("s6_chk",      32'(chk_b), 32'hA5);
    tick();
    chk("s6_busy_end", 32'(busy_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_array_collector.md
Name: inst_array_collector

Overview:
- Consumes the per-instance outputs of a 2-D module-instance array (ROWS x COLS instances, one W-bit word each).
- Serializes them in row-major order onto a valid/ready stream, tagging each word with its [row][col] index and accumulating an XOR checksum.
- Sits directly downstream of the instance array and feeds the self-check or display logic, so per-instance results become checkable in order.

Parameters:
- ROWS, 3, first (outer) array dimension.
- COLS, 2, second (inner) array dimension.
- W, 8, bits per instance word.
- ROW_W, max(1,$clog2(ROWS)), derived width of out_row.
- COL_W, max(1,$clog2(COLS)), derived width of out_col.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a snapshot-and-scan; sampled only in IDLE.
- in_data  input  ROWS*COLS*W  flattened array; element [r][c] at bits (r*COLS+c)*W +: W.
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  consumer accepts the word; transfer when out_valid && out_ready.
- out_data  output  W  current element.
- out_row  output  ROW_W  row index of out_data.
- out_col  output  COL_W  column index of out_data.
- out_last  output  1  high with the final element [ROWS-1][COLS-1].
- busy  output  1  high in SEND and DONE.
- done  output  1  one-cycle pulse after the last transfer.
- checksum  output  W  XOR of all words transferred in the current/last scan.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; snapshot and indices cleared. Reset mid-scan aborts immediately, with no done pulse.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - start=1 at an edge captures all of in_data into an internal snapshot, clears checksum, sets row=col=0, and moves to SEND.
  - out_valid rises the cycle after start.
- SEND:
  - out_valid=1, out_data=snapshot[row][col], out_last=(row==ROWS-1 && col==COLS-1).
  - On a transfer: checksum ^= out_data; col increments; when col==COLS-1, col wraps to 0 and row increments.
  - A transfer on out_last goes to DONE instead of advancing.
  - If out_ready=0, all out_* hold stable; no index or checksum change.
- DONE: out_valid=0, done=1 for exactly one cycle, then IDLE. Checksum holds its value until the next start.
- start outside IDLE is ignored, not queued. Changes on in_data after the capture edge do not affect the scan.
- Throughput: one word per cycle with out_ready held high. Scan of N=ROWS*COLS words takes N cycles in SEND plus 1 cycle in DONE.
- Degenerate ROWS=COLS=1: a single word with out_last=1, then DONE.
- Row/col counters never exceed ROWS-1/COLS-1; no out-of-range index is ever presented.

Test Plan:
1. ROWS=3, COLS=2, W=8, element[r][c]=0x10*r+c, out_ready=1, start pulse at cycle 0. Required response:
   - out_data 00,01,10,11,20,21 on cycles 1-6, with (row,col) (0,0)…(2,1).
   - out_last only on 21.
   - done=1 at cycle 7; checksum=0x01; busy low from cycle 8.
2. Same data, out_ready toggling 1,0,0,1,... Required response: each word held stable while out_ready=0; sequence and checksum identical to scenario 1; done one cycle after the final accepted word.
3. Overwrite in_data with all 0xFF one cycle after start. Required response: the stream still emits 00,01,10,11,20,21 from the snapshot.
4. Pulse start again during SEND at word 11. Required response: ignored; exactly 6 words and one done pulse. A start in the cycle after done begins a fresh scan with checksum cleared.
5. Assert rst_n=0 mid-scan after word 10. Required response: out_valid, busy, done and checksum read 0 asynchronously; no done pulse; a subsequent start restarts at (0,0).
6. ROWS=1, COLS=1, element=0xA5. Required response: a single word 0xA5 with out_last=1; done next cycle; checksum=0xA5.
